// File: rtl/div16.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/ready handshake and a one-cycle valid pulse when results land.
module div16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // The partial remainder is always below the divisor between steps, so
    // only its shifted form needs the extra bit.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] diff_lo;
    logic             carry_lo;
    logic             no_borrow;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    assign r_shift = {r_q, q_q[WIDTH-1]};

    // Trial subtraction as r_shift + ~{0,D} + 1. The top bit of the inverted
    // divisor is 1, so the final carry-out reduces to r_shift[WIDTH] | carry_lo.
    assign {carry_lo, diff_lo} = {1'b0, r_shift[WIDTH-1:0]} + {1'b0, ~d_q}
                                 + {{WIDTH{1'b0}}, 1'b1};
    assign no_borrow = r_shift[WIDTH] | carry_lo;

    assign q_next = {q_q[WIDTH-2:0], no_borrow};
    assign r_next = no_borrow ? diff_lo : r_shift[WIDTH-1:0];

    // NOTE: every _d gets its hold value first so no path through this block
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividend;
                        d_d     = divisor;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_next;
                    rem_d   = r_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN);
    assign valid       = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16.sv
// Self-checking bench for div16: directed cases, divide-by-zero, held start,
// mid-run reset and randomized operands against an arithmetic reference.
module tb_div16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int passes = 0;

    div16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: {quotient, remainder, div_by_zero}
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {{W{1'b1}}, a, 1'b1};
        return {W'(a / b), W'(a % b), 1'b0};
    endfunction

    // Cycle monitor: state exclusivity, one-cycle valid, results held between valids.
    bit           mon_en = 1'b0;
    logic         rst_edge = 1'b0;
    logic         prev_valid = 1'b0;
    logic         prev_busy = 1'b0;
    logic [2*W:0] held = '0;

    always @(posedge clk) rst_edge = !rst_n;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($onehot({ready, busy, valid})) passes++;
            else $display("FAIL state_onehot: ready/busy/valid=%b%b%b, required exactly one high",
                          ready, busy, valid);
            if (valid) begin
                checks++;
                if (!prev_valid) passes++;
                else $display("FAIL valid_width: valid high two cycles in a row, required one-cycle pulse");
                held = {quotient, remainder, div_by_zero};
            end else begin
                if (rst_edge) held = '0;
                else if (busy && !prev_busy) held[0] = 1'b0;
                checks++;
                if ({quotient, remainder, div_by_zero} === held) passes++;
                else $display("FAIL result_hold: got %h, required %h",
                              {quotient, remainder, div_by_zero}, held);
            end
            prev_valid = valid;
            prev_busy  = busy;
        end
    end

    // Drives one operation from a negedge; returns results, edges from accept to
    // valid, busy cycles observed, and ready one cycle after valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W:0] got, output int lat,
                          output int busy_n, output logic ready_after);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 0;
        busy_n   = 0;
        while (!valid && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        got = {quotient, remainder, div_by_zero};
        @(negedge clk);
        ready_after = ready;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready, busy, valid} === 3'b100) passes++;
        else $display("FAIL reset_state: ready/busy/valid=%b%b%b, required 100", ready, busy, valid);
        checks++;
        if ({quotient, remainder, div_by_zero} === '0) passes++;
        else $display("FAIL reset_outputs: got %h, required 0", {quotient, remainder, div_by_zero});
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{16'd100, 16'hFFFF, 16'hFFFF, 16'd3};
        logic [W-1:0] tb [4] = '{16'd7,   16'h0001, 16'hFFFF, 16'd9};
        logic [2*W:0] got, exp;
        int lat, bn;
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], got, lat, bn, rdy);
            exp = ref_div(ta[i], tb[i]);
            checks++;
            if (got === exp) passes++;
            else $display("FAIL directed_result[%0d]: got %h, required %h", i, got, exp);
            checks++;
            if (lat == W) passes++;
            else $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, W);
            checks++;
            if (bn == W) passes++;
            else $display("FAIL directed_busy[%0d]: got %0d, required %0d", i, bn, W);
            checks++;
            if (rdy === 1'b1) passes++;
            else $display("FAIL directed_ready_after[%0d]: got %b, required 1", i, rdy);
        end
    endtask

    task automatic test_div_by_zero();
        logic [W-1:0] ta [3] = '{16'd5, 16'd10, 16'hABCD};
        logic [W-1:0] tb [3] = '{16'd0, 16'd3,  16'd0};
        logic [2*W:0] got, exp;
        int lat, bn, exp_lat;
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], got, lat, bn, rdy);
            exp     = ref_div(ta[i], tb[i]);
            exp_lat = (tb[i] == '0) ? 0 : W;
            checks++;
            if (got === exp) passes++;
            else $display("FAIL dbz_result[%0d]: got %h, required %h", i, got, exp);
            checks++;
            if (lat == exp_lat) passes++;
            else $display("FAIL dbz_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
            checks++;
            if (bn == exp_lat) passes++;
            else $display("FAIL dbz_busy[%0d]: got %0d, required %0d", i, bn, exp_lat);
        end
    endtask

    task automatic test_start_held();
        logic [2*W:0] expq[$];
        logic [2*W:0] exp;
        logic [W-1:0] a, b;
        int done_n = 0;
        int acc_n  = 0;
        start = 1'b1;
        for (int cyc = 0; cyc < 120; cyc++) begin
            if (valid) begin
                checks++;
                if (expq.size() == 0) begin
                    $display("FAIL held_start_extra: valid with no accepted operation");
                end else begin
                    exp = expq.pop_front();
                    if ({quotient, remainder, div_by_zero} === exp) passes++;
                    else $display("FAIL held_start_result: got %h, required %h",
                                  {quotient, remainder, div_by_zero}, exp);
                end
                done_n++;
            end
            a = W'($urandom);
            if (ready) begin
                b = (acc_n % 3 == 2) ? '0 : W'($urandom_range(1, 2000));
                expq.push_back(ref_div(a, b));
                acc_n++;
            end else begin
                b = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
            end
            dividend = a;
            divisor  = b;
            @(negedge clk);
        end
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && expq.size() != 0; cyc++) begin
            if (valid) begin
                exp = expq.pop_front();
                checks++;
                if ({quotient, remainder, div_by_zero} === exp) passes++;
                else $display("FAIL held_start_result: got %h, required %h",
                              {quotient, remainder, div_by_zero}, exp);
                done_n++;
            end
            @(negedge clk);
        end
        checks++;
        if (done_n == acc_n && acc_n >= 6) passes++;
        else $display("FAIL held_start_count: completed %0d, accepted %0d (need >= 6 and equal)",
                      done_n, acc_n);
    endtask

    task automatic test_reset_mid_run();
        logic [2*W:0] got, exp;
        int lat, bn;
        logic rdy;
        logic saw_valid = 1'b0;
        for (int n = 0; n < 50 && !ready; n++) @(negedge clk);
        dividend = 16'd50000;
        divisor  = 16'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({ready, busy, valid} === 3'b100) passes++;
        else $display("FAIL abort_state: ready/busy/valid=%b%b%b, required 100", ready, busy, valid);
        checks++;
        if ({quotient, remainder, div_by_zero} === '0) passes++;
        else $display("FAIL abort_outputs: got %h, required 0", {quotient, remainder, div_by_zero});
        for (int n = 0; n < 20; n++) begin
            if (valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (!saw_valid) passes++;
        else $display("FAIL abort_no_valid: valid seen after reset abort, required none");
        run_op(16'd1000, 16'd10, got, lat, bn, rdy);
        exp = ref_div(16'd1000, 16'd10);
        checks++;
        if (got === exp && lat == W) passes++;
        else $display("FAIL abort_recover: got %h lat %0d, required %h lat %0d", got, lat, exp, W);
    endtask

    task automatic test_random();
        logic [2*W:0] got, exp;
        logic [W-1:0] a, b;
        int lat, bn, exp_lat;
        logic rdy;
        for (int i = 0; i < 2500; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = '1;
                3:       b = a;
                4:       b = W'($urandom_range(1, 255));
                default: b = W'($urandom);
            endcase
            run_op(a, b, got, lat, bn, rdy);
            exp     = ref_div(a, b);
            exp_lat = (b == '0) ? 0 : W;
            checks++;
            if (got === exp) passes++;
            else $display("FAIL random_result %h/%h: got %h, required %h", a, b, got, exp);
            checks++;
            if (lat == exp_lat && bn == exp_lat && rdy === 1'b1) passes++;
            else $display("FAIL random_timing %h/%h: lat %0d busy %0d ready %b, required %0d %0d 1",
                          a, b, lat, bn, rdy, exp_lat, exp_lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_held();
        test_reset_mid_run();
        test_random();
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
